data_mem_resp: RTL

- Word-addressed data memory that answers the processor's load/store requests (LW/SW).
- Sits on the memory side of the datapath's data port.
- Uses a valid/ready request channel and a valid/ready response channel, with a programmable access latency.
- Lets the processor be exercised against a memory that is multi-cycle and can stall.

---
 rtl/data_mem_resp.sv | 71 +++++++
 1 files changed

// File: rtl/data_mem_resp.sv
// data_mem_resp: word-addressed LW/SW data memory with valid/ready request and response
// channels and a programmable number of wait cycles per access.
module data_mem_resp #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 32,
  parameter int LAT    = 2
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              req_valid,
  input  logic              req_we,
  input  logic [31:0]       req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              req_ready,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_err
);
  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;
  state_t state, nxt;
  logic [3:0] cnt;
  logic we_q, mis_q, fire, commit, addr_unused;
  logic [ADDR_W-1:0] idx_q;
  logic [DATA_W-1:0] wdata_q;
  logic [DATA_W-1:0] mem [2**ADDR_W];
  assign addr_unused = ^req_addr[31:ADDR_W+2];
  assign req_ready = state == IDLE;
  assign rsp_valid = state == RESP;
  // WAIT spans LAT+1 cycles, so the response lands LAT+1 edges after the accept edge
  assign fire = state == WAIT && cnt == 4'd0;
  assign commit = fire && we_q && !mis_q;
  always_comb begin
    nxt = state;
    case (state)
      IDLE:    nxt = req_valid ? WAIT : IDLE;
      WAIT:    nxt = cnt == 4'd0 ? RESP : WAIT;
      RESP:    nxt = rsp_ready ? IDLE : RESP;
      default: nxt = IDLE;
    endcase
  end
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state     <= IDLE;
      cnt       <= 4'd0;
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
    end else begin
      state <= nxt;
      cnt   <= state == IDLE ? 4'(LAT) : cnt - 4'd1;
      if (fire) begin
        rsp_rdata <= (we_q || mis_q) ? '0 : mem[idx_q];
        rsp_err   <= mis_q;
      end else if (state == RESP && rsp_ready) begin
        rsp_rdata <= '0;
        rsp_err   <= 1'b0;
      end
    end
  end
  // Request payload and array carry no reset: memory survives reset, and a store is only
  // committed on the fire edge, which cannot occur while reset holds the FSM in IDLE.
  always_ff @(posedge CLK) begin
    if (state == IDLE && req_valid) begin
      we_q    <= req_we;
      mis_q   <= req_addr[1:0] != 2'b00;
      idx_q   <= req_addr[ADDR_W+1:2];
      wdata_q <= req_wdata;
    end
    if (commit) mem[idx_q] <= wdata_q;
  end
endmodule
